// File: rtl/mips_reg_pkg.sv
// ---------------------------------------------------------------------------
// mips_reg_pkg
//  Shared definitions for the MIPS general-purpose register bank.
//  Holds the architectural register indices that get special treatment
//  ($zero, $sp, $ra), the $sp reset value and the index/word types.
// ---------------------------------------------------------------------------
package mips_reg_pkg;

   typedef logic [4:0]  reg_idx_t;
   typedef logic [31:0] word_t;

   localparam reg_idx_t REG_ZERO     = 5'd0;
   localparam reg_idx_t REG_SP       = 5'd29;
   localparam reg_idx_t REG_RA       = 5'd31;
   localparam word_t    SP_RESET_VAL = 32'd227;

endpackage : mips_reg_pkg

// File: rtl/reg_read_port.sv
// ---------------------------------------------------------------------------
// reg_read_port
//  One combinational read port of the register bank: selects the indexed
//  word from the flattened storage, forces index 0 to zero and, when the
//  REG_BYPASS_EN macro is defined, forwards same-cycle write data.
//
//  Configuration macro: REG_BYPASS_EN (adds the wr_hit/wr_addr/wr_data ports)
//
//  Ports
//   regs     in   2**ADDR_W x DATA_W  stored register contents
//   rd_addr  in   ADDR_W              read index
//   wr_hit   in   1                   a real write is committing this cycle (bypass build only)
//   wr_addr  in   ADDR_W              write index (bypass build only)
//   wr_data  in   DATA_W              write data (bypass build only)
//   rd_data  out  DATA_W              read data, zero latency
// ---------------------------------------------------------------------------
module reg_read_port
   import mips_reg_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
   input  logic [ADDR_W-1:0]                  rd_addr,
`ifdef REG_BYPASS_EN
   input  logic                               wr_hit,
   input  logic [ADDR_W-1:0]                  wr_addr,
   input  logic [DATA_W-1:0]                  wr_data,
`endif
   output logic [DATA_W-1:0]                  rd_data
);

   // Read mux: $zero always reads zero; wr_hit already excludes index 0,
   // so the zero test must come first to keep $zero from ever forwarding.
   always_comb begin
      rd_data = '0;
      if (rd_addr == ADDR_W'(REG_ZERO)) begin
         rd_data = '0;
      end
`ifdef REG_BYPASS_EN
      else if (wr_hit && (rd_addr == wr_addr)) begin
         rd_data = wr_data;
      end
`endif
      else begin
         rd_data = regs[rd_addr];
      end
   end

endmodule : reg_read_port

// File: rtl/reg_bank_rw.sv
// ---------------------------------------------------------------------------
// reg_bank_rw
//  32 x 32-bit MIPS general-purpose register bank. Two combinational read
//  ports (rs, rt), one clocked write port, $zero hard-wired to zero and
//  $sp preset on reset. A 16-bit debug counter tracks committed writes.
//
//  Configuration macro: REG_BYPASS_EN (same-cycle write-through forwarding
//  on both read ports; when undefined reads return the pre-edge value)
//
//  Ports
//   clk       in   1       rising-edge clock
//   reset_n   in   1       asynchronous active-low reset
//   rs_addr   in   ADDR_W  read port A index
//   rt_addr   in   ADDR_W  read port B index
//   rs_data   out  DATA_W  read port A data
//   rt_data   out  DATA_W  read port B data
//   wr_en     in   1       register write enable
//   wr_addr   in   ADDR_W  write destination index
//   wr_data   in   DATA_W  write-back data
//   wr_count  out  16      committed-write counter, wraps at 16'hFFFF
// ---------------------------------------------------------------------------
module reg_bank_rw
   import mips_reg_pkg::*;
#(
   parameter int                 DATA_W   = 32,
   parameter int                 ADDR_W   = 5,
   parameter int                 SP_IDX   = 29,
   parameter logic [DATA_W-1:0]  SP_RESET = SP_RESET_VAL
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [15:0]       wr_count
);

   localparam int                NREGS  = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] SP_SEL = ADDR_W'(SP_IDX);

   logic [NREGS-1:0][DATA_W-1:0] regs_r;
   logic [15:0]                  wr_count_r;
   logic                         wr_hit_s;

   // A write commits only outside reset and never to $zero. Folding reset_n
   // in here also stops the bypass path from forwarding while reset is held,
   // so reads during reset show the reset contents.
   always_comb begin
      wr_hit_s = 1'b0;
      if (reset_n && wr_en && (wr_addr != ADDR_W'(REG_ZERO))) begin
         wr_hit_s = 1'b1;
      end else begin
         wr_hit_s = 1'b0;
      end
   end

   // Storage array and write path; reset clears everything except the stack pointer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         regs_r         <= '0;
         regs_r[SP_SEL] <= SP_RESET;
      end else if (wr_hit_s) begin
         regs_r[wr_addr] <= wr_data;
      end else begin
         regs_r <= regs_r;
      end
   end

   // Committed-write counter; free-running wrap from 16'hFFFF to 16'h0000.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_count_r <= 16'd0;
      end else if (wr_hit_s) begin
         wr_count_r <= wr_count_r + 16'd1;
      end else begin
         wr_count_r <= wr_count_r;
      end
   end

   assign wr_count = wr_count_r;

   reg_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rs_port (
      .regs    (regs_r),
      .rd_addr (rs_addr),
`ifdef REG_BYPASS_EN
      .wr_hit  (wr_hit_s),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
`endif
      .rd_data (rs_data)
   );

   reg_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rt_port (
      .regs    (regs_r),
      .rd_addr (rt_addr),
`ifdef REG_BYPASS_EN
      .wr_hit  (wr_hit_s),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
`endif
      .rd_data (rt_data)
   );

endmodule : reg_bank_rw

// File: tb/tb_reg_bank_rw.sv
// ---------------------------------------------------------------------------
// tb_reg_bank_rw
//  Self-checking bench for reg_bank_rw. A plain array of 32 words plus an
//  integer write count act as the reference; reads are predicted from the
//  architectural rules ($zero reads 0, optional same-cycle forwarding).
//  Inputs change one time unit after a rising edge; reads are sampled
//  before the next rising edge.
// ---------------------------------------------------------------------------
module tb_reg_bank_rw;
   import mips_reg_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [15:0] wr_count;

   int checks = 0;
   int errors = 0;

   logic [31:0] model [32];
   int          model_count;

   always #5 clk = ~clk;

   reg_bank_rw dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .rs_addr  (rs_addr),
      .rt_addr  (rt_addr),
      .rs_data  (rs_data),
      .rt_data  (rt_data),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_count (wr_count)
   );

   // Reference reset state.
   task automatic model_reset();
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      model[29]   = 32'd227;
      model_count = 0;
   endtask

   // Expected read value for an index given the current inputs.
   function automatic logic [31:0] exp_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
`ifdef REG_BYPASS_EN
      if (reset_n && wr_en && (wr_addr != 5'd0) && (a == wr_addr)) return wr_data;
`endif
      return model[a];
   endfunction

   // Advance one rising edge and apply the write to the reference.
   task automatic clock_write();
      @(posedge clk);
      if (reset_n && wr_en && (wr_addr != 5'd0)) begin
         model[wr_addr] = wr_data;
         model_count    = (model_count + 1) % 65536;
      end
      #1;
   endtask

   task automatic test_reset();
      wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
      rs_addr = 5'd29; rt_addr = 5'd5;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      model_reset();
      #2;
      checks++; if (rs_data !== 32'd227) begin errors++; $display("FAIL reset_sp: got %h want %h", rs_data, 32'd227); end
      checks++; if (rt_data !== 32'd0)   begin errors++; $display("FAIL reset_r5: got %h want %h", rt_data, 32'd0); end
      checks++; if (wr_count !== 16'd0)  begin errors++; $display("FAIL reset_count: got %0d want 0", wr_count); end
      reset_n = 1'b1;
      #1;
      checks++; if (rs_data !== 32'd227) begin errors++; $display("FAIL reset_release_sp: got %h want %h", rs_data, 32'd227); end
   endtask

   task automatic test_write();
      @(posedge clk); #1;
      wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'hDEADBEEF; rs_addr = 5'd8; rt_addr = 5'd0;
      clock_write();
      wr_en = 1'b0;
      #1;
      checks++; if (rs_data !== 32'hDEADBEEF) begin errors++; $display("FAIL write_r8: got %h want %h", rs_data, 32'hDEADBEEF); end
      checks++; if (wr_count !== 16'd1)       begin errors++; $display("FAIL write_count: got %0d want 1", wr_count); end
   endtask

   task automatic test_zero_write();
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rs_addr = 5'd0; rt_addr = 5'd0;
      #1;
      checks++; if (rs_data !== 32'd0) begin errors++; $display("FAIL zero_pre_edge: got %h want 0", rs_data); end
      clock_write();
      wr_en = 1'b0;
      #1;
      checks++; if (rs_data !== 32'd0) begin errors++; $display("FAIL zero_post_edge: got %h want 0", rs_data); end
      checks++; if (wr_count !== 16'(model_count)) begin errors++; $display("FAIL zero_count: got %0d want %0d", wr_count, model_count); end
   endtask

   task automatic test_same_cycle();
      logic [31:0] pre_exp;
`ifdef REG_BYPASS_EN
      pre_exp = 32'h55;
`else
      pre_exp = 32'h11;
`endif
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h11;
      clock_write();
      wr_data = 32'h55; rs_addr = 5'd9; rt_addr = 5'd9;
      #1;
      checks++; if (rs_data !== pre_exp) begin errors++; $display("FAIL same_cycle_rs_pre: got %h want %h", rs_data, pre_exp); end
      checks++; if (rt_data !== pre_exp) begin errors++; $display("FAIL same_cycle_rt_pre: got %h want %h", rt_data, pre_exp); end
      clock_write();
      wr_en = 1'b0;
      #1;
      checks++; if (rs_data !== 32'h55) begin errors++; $display("FAIL same_cycle_rs_post: got %h want %h", rs_data, 32'h55); end
      checks++; if (rt_data !== 32'h55) begin errors++; $display("FAIL same_cycle_rt_post: got %h want %h", rt_data, 32'h55); end
   endtask

   task automatic test_sp_ra_reset();
      wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h400;
      clock_write();
      wr_addr = 5'd29; wr_data = 32'h100;
      clock_write();
      wr_en = 1'b0; rs_addr = 5'd31; rt_addr = 5'd29;
      #1;
      checks++; if (rs_data !== 32'h400) begin errors++; $display("FAIL ra_write: got %h want %h", rs_data, 32'h400); end
      checks++; if (rt_data !== 32'h100) begin errors++; $display("FAIL sp_write: got %h want %h", rt_data, 32'h100); end
      // Write in flight when reset lands; reset must win.
      wr_en = 1'b1; wr_addr = 5'd29; wr_data = 32'hCAFE0001; rs_addr = 5'd29; rt_addr = 5'd31;
      #1 reset_n = 1'b0;
      model_reset();
      #1;
      checks++; if (rs_data !== 32'd227) begin errors++; $display("FAIL midreset_sp: got %h want %h", rs_data, 32'd227); end
      checks++; if (rt_data !== 32'd0)   begin errors++; $display("FAIL midreset_ra: got %h want 0", rt_data); end
      checks++; if (wr_count !== 16'd0)  begin errors++; $display("FAIL midreset_count: got %0d want 0", wr_count); end
      clock_write();
      wr_en = 1'b0;
      reset_n = 1'b1;
      #1;
      checks++; if (rs_data !== 32'd227) begin errors++; $display("FAIL postreset_sp: got %h want %h", rs_data, 32'd227); end
      checks++; if (rt_data !== 32'd0)   begin errors++; $display("FAIL postreset_ra: got %h want 0", rt_data); end
   endtask

   task automatic test_random();
      logic [31:0] e_rs;
      logic [31:0] e_rt;
      for (int n = 0; n < 300; n++) begin
         wr_en   = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 7))
            0:       wr_addr = 5'd0;
            1:       wr_addr = 5'd29;
            2:       wr_addr = 5'd31;
            default: wr_addr = 5'($urandom_range(0, 31));
         endcase
         wr_data = $urandom;
         rs_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
         rt_addr = ($urandom_range(0, 3) == 0) ? rs_addr : 5'($urandom_range(0, 31));
         #1;
         e_rs = exp_read(rs_addr);
         e_rt = exp_read(rt_addr);
         checks++; if (rs_data !== e_rs) begin errors++; $display("FAIL rand_rs[%0d] idx %0d: got %h want %h", n, rs_addr, rs_data, e_rs); end
         checks++; if (rt_data !== e_rt) begin errors++; $display("FAIL rand_rt[%0d] idx %0d: got %h want %h", n, rt_addr, rt_data, e_rt); end
         checks++; if (wr_count !== 16'(model_count)) begin errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", n, wr_count, model_count); end
         clock_write();
      end
      wr_en = 1'b0;
   endtask

   task automatic test_wrap();
      logic [31:0] last_data;
      last_data = 32'd0;
      reset_n = 1'b0;
      #1 reset_n = 1'b1;
      model_reset();
      wr_en = 1'b1; wr_addr = 5'd1; rs_addr = 5'd1; rt_addr = 5'd0;
      for (int i = 0; i < 65536; i++) begin
         wr_data   = $urandom;
         last_data = wr_data;
         clock_write();
         if (i == 65534) begin
            checks++; if (wr_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_max: got %h want FFFF", wr_count); end
         end
      end
      wr_en = 1'b0;
      #1;
      checks++; if (wr_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h want 0000", wr_count); end
      checks++; if (wr_count !== 16'(model_count)) begin errors++; $display("FAIL wrap_model: got %0d want %0d", wr_count, model_count); end
      checks++; if (rs_data !== last_data) begin errors++; $display("FAIL wrap_r1: got %h want %h", rs_data, last_data); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_zero_write();
      test_same_cycle();
      test_sp_ra_reset();
      test_random();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_reg_bank_rw
